uv_dequant_reconstruct: RTL and testbench

//  Decoder-side chroma reconstruction for one macroblock (U 8x8 + V 8x8, eight 4x4 blocks).

---
 rtl/uv_dequant_reconstruct.sv | 242 ++++++++++++++++++++++++
 tb/tb_uv_dequant_reconstruct.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uv_dequant_reconstruct.sv
// Chroma (U+V) reconstruction for one macroblock: eight 4x4 blocks run serially
// through one dequantizer / VP8 inverse transform / prediction-add datapath.
// Blocks flagged all-zero copy their prediction straight to the output.
module uv_dequant_reconstruct #(
  parameter int BLOCK_SIZE = 8,
  parameter int CW         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [BLOCK_SIZE*16*CW-1:0]  UVlevels,
  input  logic [1023:0]                UVPred,
  input  logic [16*CW-1:0]             dq,
  input  logic [31:0]                  nz,
  output logic [1023:0]                UVout,
  output logic                         busy,
  output logic                         done
);

  localparam int BW = $clog2(BLOCK_SIZE);
  localparam int TW = CW + 4;

  // DONE holds the FSM out of IDLE while the done pulse is high, so a start
  // coincident with done is not taken.
  typedef enum logic [2:0] {
    S_IDLE, S_COPY, S_DEQ, S_VERT, S_HORZ, S_FIN, S_DONE
  } state_t;

  state_t state, next_state;

  logic [BLOCK_SIZE*16*CW-1:0] levels_r;
  logic [1023:0]               pred_r;
  logic [16*CW-1:0]            dq_r;
  logic [31:0]                 nz_r;
  logic [BW-1:0]               blk;

  logic signed [CW-1:0] coef_r [16];
  logic signed [TW-1:0] t_r    [16];

  logic [16*CW-1:0]     lvl_blk_s;
  logic signed [CW-1:0] deq_s      [16];
  logic signed [TW-1:0] col_s      [16];
  logic [7:0]           pred_blk_s [16];
  logic [7:0]           pix_s      [16];
  logic [7:0]           wr_byte_s  [16];
  logic [9:0]           wr_idx_s   [16];

  logic          accept_s;
  logic          advance_s;
  logic          last_blk_s;
  logic [BW-1:0] nxt_blk_s;
  logic          nz_next_s;

  // Signed level times unsigned factor, saturated to the coefficient range.
  function automatic logic signed [CW-1:0] dequant(input logic signed [CW-1:0] lv,
                                                  input logic [CW-1:0] q);
    logic signed [2*CW:0] p;
    p = (2*CW+1)'(lv) * $signed({{(CW+1){1'b0}}, q});
    if (p > $signed({{(CW+2){1'b0}}, {(CW-1){1'b1}}})) begin
      return {1'b0, {(CW-1){1'b1}}};
    end else if (p < $signed({{(CW+2){1'b1}}, {(CW-1){1'b0}}})) begin
      return {1'b1, {(CW-1){1'b0}}};
    end else begin
      return p[CW-1:0];
    end
  endfunction

  // x * sqrt(2)*cos(pi/8) in VP8 fixed point.
  function automatic logic signed [31:0] m1(input logic signed [31:0] x);
    logic signed [47:0] p;
    p = 48'(x) * 48'sd20091;
    return 32'(p >>> 16) + x;
  endfunction

  // x * sqrt(2)*sin(pi/8) in VP8 fixed point.
  function automatic logic signed [31:0] m2(input logic signed [31:0] x);
    logic signed [47:0] p;
    p = 48'(x) * 48'sd35468;
    return 32'(p >>> 16);
  endfunction

  // One 4-point butterfly; returns {o3, o2, o1, o0}.
  function automatic logic [127:0] bfly(input logic signed [31:0] i0,
                                        input logic signed [31:0] i1,
                                        input logic signed [31:0] i2,
                                        input logic signed [31:0] i3);
    logic signed [31:0] a, b, c, d;
    a = i0 + i2;
    b = i0 - i2;
    c = m2(i1) - m1(i3);
    d = m1(i1) + m2(i3);
    return {a - d, b - c, b + c, a + d};
  endfunction

  function automatic logic [7:0] clip8(input logic signed [31:0] v);
    if (v < 32'sd0) begin
      return 8'd0;
    end else if (v > 32'sd255) begin
      return 8'd255;
    end else begin
      return v[7:0];
    end
  endfunction

  assign accept_s   = (state == S_IDLE) && start;
  assign advance_s  = (state == S_COPY) || (state == S_HORZ);
  assign last_blk_s = (blk == BW'(BLOCK_SIZE - 1));
  assign nxt_blk_s  = blk + BW'(1);
  assign nz_next_s  = nz_r[16 + int'(nxt_blk_s)];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: block selection is folded into the edge that leaves the previous block
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = nz[16] ? S_DEQ : S_COPY;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_COPY, S_HORZ: begin
        if (last_blk_s) begin
          next_state = S_FIN;
        end else begin
          next_state = nz_next_s ? S_DEQ : S_COPY;
        end
      end
      S_DEQ:   next_state = S_VERT;
      S_VERT:  next_state = S_HORZ;
      S_FIN:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Input capture on accepted start, block index, busy and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      levels_r <= '0;
      pred_r   <= '0;
      dq_r     <= '0;
      nz_r     <= '0;
      blk      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (accept_s) begin
        levels_r <= UVlevels;
        pred_r   <= UVPred;
        dq_r     <= dq;
        nz_r     <= nz;
        blk      <= '0;
        busy     <= 1'b1;
      end else if (state == S_FIN) begin
        busy <= 1'b0;
      end else if (advance_s) begin
        blk <= nxt_blk_s;
      end
    end
  end

  // Shared datapath: dequant, column pass, row pass with prediction add, byte placement
  always_comb begin
    logic [127:0] y;
    logic [2:0]   row;
    logic [3:0]   col;
    y         = '0;
    row       = '0;
    col       = '0;
    lvl_blk_s = levels_r[int'(blk)*(16*CW) +: 16*CW];
    for (int i = 0; i < 16; i++) begin
      deq_s[i] = dequant(lvl_blk_s[i*CW +: CW], dq_r[i*CW +: CW]);
    end
    for (int j = 0; j < 4; j++) begin
      y = bfly(32'(coef_r[j]), 32'(coef_r[4+j]), 32'(coef_r[8+j]), 32'(coef_r[12+j]));
      col_s[j]    = y[TW-1:0];
      col_s[4+j]  = y[32+TW-1:32];
      col_s[8+j]  = y[64+TW-1:64];
      col_s[12+j] = y[96+TW-1:96];
    end
    for (int r = 0; r < 4; r++) begin
      y = bfly(32'(t_r[4*r]) + 32'sd4, 32'(t_r[4*r+1]), 32'(t_r[4*r+2]), 32'(t_r[4*r+3]));
      for (int c = 0; c < 4; c++) begin
        row = {blk[1], 2'b00} + 3'(r);
        col = {blk[2], blk[0], 2'b00} + 4'(c);
        wr_idx_s[4*r+c]   = {row, col, 3'b000};
        pred_blk_s[4*r+c] = pred_r[wr_idx_s[4*r+c] +: 8];
        pix_s[4*r+c]      = clip8(($signed(y[32*c +: 32]) >>> 3) +
                                  $signed({24'd0, pred_blk_s[4*r+c]}));
        if (state == S_COPY) begin
          wr_byte_s[4*r+c] = pred_blk_s[4*r+c];
        end else begin
          wr_byte_s[4*r+c] = pix_s[4*r+c];
        end
      end
    end
  end

  // Pipeline registers between dequant, column pass and row pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        coef_r[i] <= '0;
        t_r[i]    <= '0;
      end
    end else begin
      if (state == S_DEQ) begin
        for (int i = 0; i < 16; i++) begin
          coef_r[i] <= deq_s[i];
        end
      end
      if (state == S_VERT) begin
        for (int i = 0; i < 16; i++) begin
          t_r[i] <= col_s[i];
        end
      end
    end
  end

  // Output frame: a block's 16 bytes are written on its COPY or HORZ edge only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      UVout <= '0;
    end else if (advance_s) begin
      for (int i = 0; i < 16; i++) begin
        UVout[wr_idx_s[i] +: 8] <= wr_byte_s[i];
      end
    end
  end

endmodule

// File: tb/tb_uv_dequant_reconstruct.sv
// Directed bench for uv_dequant_reconstruct with hand-computed pixel values.
module tb_uv_dequant_reconstruct;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2047:0] UVlevels;
  logic [1023:0] UVPred;
  logic [255:0]  dq;
  logic [31:0]   nz;
  logic [1023:0] UVout;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1023:0] snap;
  logic [1023:0] exp_v;
  logic [1023:0] p_v;
  logic [2047:0] lv3;
  logic [1023:0] p3;
  logic [255:0]  dq3;
  logic [1023:0] exp3;

  always #5 clk = ~clk;

  uv_dequant_reconstruct #(.BLOCK_SIZE(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .UVlevels(UVlevels), .UVPred(UVPred),
    .dq(dq), .nz(nz), .UVout(UVout), .busy(busy), .done(done)
  );

  task automatic check_val(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int d;
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      d = 0;
      for (int i = 127; i >= 0; i--) begin
        if (got[8*i +: 8] !== exp[8*i +: 8]) d = i;
      end
      $display("FAIL %s: byte %0d got %0h expected %0h", tag, d, got[8*d +: 8], exp[8*d +: 8]);
    end
  endtask

  function automatic int pix_bit(input int k, input int r, input int c);
    return 128 * (4 * ((k >> 1) & 1) + r) + 8 * (8 * ((k >> 2) & 1) + 4 * (k & 1) + c);
  endfunction

  function automatic logic [1023:0] fill_blk(input logic [1023:0] v, input int k, input logic [7:0] b);
    logic [1023:0] o;
    o = v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[pix_bit(k, r, c) +: 8] = b;
      end
    end
    return o;
  endfunction

  // One operation: start, scramble inputs after acceptance, count cycles to done.
  // kick_at: extra start pulse sampled at edge E+kick_at; rst_at: reset at edge E+rst_at.
  task automatic run_op(input string tag, input int exp_cyc, input int kick_at,
                        input int rst_at, input bit kick_on_done);
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    UVPred   = ~UVPred;
    UVlevels = ~UVlevels;
    dq       = ~dq;
    nz       = ~nz;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      start = (kick_at > 0 && cyc == kick_at - 1);
      if (rst_at > 0 && cyc == rst_at - 1) begin
        rst = 1'b1;
        #1;
        check_val({tag, "_rst_out"}, UVout, '0);
        check_val({tag, "_rst_busy"}, busy, 1'b0);
        check_val({tag, "_rst_done"}, done, 1'b0);
      end else begin
        rst = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_val({tag, "_busy_early"}, busy, 1'b1);
      if (cyc == 2) snap = UVout;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    rst   = 1'b0;
    if (rst_at > 0) begin
      check_val({tag, "_no_done"}, seen, 1'b0);
    end else begin
      check_val({tag, "_latency"}, cyc, exp_cyc);
      check_val({tag, "_busy_at_done"}, busy, 1'b0);
      start = kick_on_done;
      @(negedge clk);
      start = 1'b0;
      check_val({tag, "_done_pulse"}, done, 1'b0);
      check_val({tag, "_busy_after"}, busy, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    UVlevels = '0;
    UVPred   = '0;
    dq       = '0;
    nz       = '0;
    repeat (2) @(negedge clk);
    check_val("reset_out", UVout, '0);
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_done", done, 1'b0);
    rst = 1'b0;

    // T1: all blocks skipped, arbitrary levels, start coincident with done ignored
    for (int i = 0; i < 64; i++) UVlevels[32*i +: 32] = $urandom;
    UVPred = {128{8'h80}};
    dq     = {16{16'd3}};
    nz     = 32'hFF00_FFFF;
    run_op("t1", 9, 0, 0, 1'b1);
    check_val("t1_out", UVout, {128{8'h80}});

    // T2: block 0 DC only, 1*8 -> (8+4)>>3 = 1 -> 101
    UVlevels        = '0;
    UVlevels[15:0]  = 16'd1;
    UVPred          = {128{8'd100}};
    dq              = '0;
    dq[15:0]        = 16'd8;
    nz              = 32'h0001_0000;
    run_op("t2", 11, 0, 0, 1'b0);
    check_val("t2_hold", snap, {128{8'h80}});
    check_val("t2_out", UVout, fill_blk({128{8'd100}}, 0, 8'd101));

    // T3: all nonzero; blk0 +10000 DC over pred 250 -> 255, blk1 -10000 over pred 5 -> 0
    UVlevels          = '0;
    UVlevels[15:0]    = 16'd100;
    UVlevels[256 +: 16] = 16'hFF9C;
    dq                = {16{16'd1}};
    dq[15:0]          = 16'd100;
    p_v               = fill_blk(fill_blk({128{8'd77}}, 0, 8'd250), 1, 8'd5);
    UVPred            = p_v;
    nz                = 32'h00FF_0000;
    lv3  = UVlevels;
    p3   = p_v;
    dq3  = dq;
    exp3 = fill_blk(fill_blk(p_v, 0, 8'd255), 1, 8'd0);
    run_op("t3", 25, 0, 0, 1'b0);
    check_val("t3_out", UVout, exp3);

    // T4: dequant saturation both ways, plus one AC coefficient through the transform
    UVlevels = '0;
    for (int i = 0; i < 16; i++) UVlevels[1280 + 32*i +: 32] = $urandom;
    UVlevels[512 +: 16]  = 16'h7FFF;
    UVlevels[768 +: 16]  = 16'h8000;
    UVlevels[1040 +: 16] = 16'd10;
    dq        = {16{16'd1}};
    dq[15:0]  = 16'hFFFF;
    dq[31:16] = 16'd10;
    p_v = fill_blk({128{8'd33}}, 2, 8'd0);
    p_v = fill_blk(p_v, 3, 8'd255);
    p_v = fill_blk(p_v, 4, 8'd100);
    UVPred = p_v;
    nz     = 32'h001C_0000;
    exp_v = fill_blk(p_v, 2, 8'd255);
    exp_v = fill_blk(exp_v, 3, 8'd0);
    for (int r = 0; r < 4; r++) begin
      exp_v[pix_bit(4, r, 0) +: 8] = 8'd116;
      exp_v[pix_bit(4, r, 1) +: 8] = 8'd107;
      exp_v[pix_bit(4, r, 2) +: 8] = 8'd93;
      exp_v[pix_bit(4, r, 3) +: 8] = 8'd84;
    end
    run_op("t4", 15, 0, 0, 1'b0);
    check_val("t4_out", UVout, exp_v);
    check_val("t4_blk4_row2", UVout[pix_bit(4, 2, 0) +: 32], {8'd84, 8'd93, 8'd107, 8'd116});

    // T5: alternating nonzero flags with zero levels, start while busy ignored
    UVlevels = '0;
    for (int j = 0; j < 128; j++) UVPred[8*j +: 8] = 8'(j) ^ 8'h3C;
    for (int i = 0; i < 8; i++) dq[32*i +: 32] = $urandom;
    nz    = 32'h0055_0000;
    exp_v = UVPred;
    run_op("t5", 17, 5, 0, 1'b0);
    check_val("t5_out", UVout, exp_v);

    // T6: reset mid-operation, then a fresh run of the T3 vector
    UVlevels = lv3;
    UVPred   = p3;
    dq       = dq3;
    nz       = 32'h00FF_0000;
    run_op("t6", 0, 5, 7, 1'b0);
    check_val("t6_out_after_rst", UVout, '0);
    UVlevels = lv3;
    UVPred   = p3;
    dq       = dq3;
    nz       = 32'h00FF_0000;
    run_op("t6b", 25, 0, 0, 1'b0);
    check_val("t6b_out", UVout, exp3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
